// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - RV32I fetch/PC-sequencing stage; RISCV_FETCH_PERF_EN adds retire/redirect counters
module riscv_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr,
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_4,
    input  logic            i_retire,
    input  logic            i_jump_d,
    input  logic            i_jalr_d,
    input  logic            i_branch_d,
    input  logic            i_zero_condition,
    input  logic            i_alu_zero,
    input  logic [XLEN-1:0] i_pc_imm,
    input  logic [XLEN-1:0] i_rs_imm,
    output logic            o_misalign
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]     o_cnt_instret,
    output logic [31:0]     o_cnt_redirect
`endif
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] instr, instr_nxt;
    logic            misalign, misalign_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            retire_edge;

    assign pc_plus4    = pc + XLEN'(4);
    assign taken       = i_branch_d & (i_alu_zero ^ i_zero_condition);
    assign retire_edge = (state == EXEC) & i_retire;

    // jalr beats jal beats a taken branch; fall-through is sequential
    always_comb begin
        target = pc_plus4;
        if (i_jalr_d)
            target = {i_rs_imm[XLEN-1:1], 1'b0};
        else if (i_jump_d)
            target = i_pc_imm;
        else if (taken)
            target = i_pc_imm;
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instr;
        misalign_nxt = misalign;
        case (state)
            FETCH: begin
                if (i_imem_rvalid) begin
                    instr_nxt = i_imem_rdata;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (i_retire) begin
                    pc_nxt = target;
                    if (target[1]) begin
                        misalign_nxt = 1'b1;
                        state_nxt    = HALT;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instr    <= NOP;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instr    <= instr_nxt;
            misalign <= misalign_nxt;
        end
    end

    assign o_imem_req    = (state == FETCH) & ~i_rst;
    assign o_imem_addr   = pc;
    assign o_instr       = instr;
    assign o_instr_valid = (state == EXEC);
    assign o_pc          = pc;
    assign o_pc_4        = pc_plus4;
    assign o_misalign    = misalign;

`ifdef RISCV_FETCH_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt_instret  <= 32'd0;
            o_cnt_redirect <= 32'd0;
        end else if (retire_edge) begin
            o_cnt_instret <= o_cnt_instret + 32'd1;
            if (target != pc_plus4)
                o_cnt_redirect <= o_cnt_redirect + 32'd1;
        end
    end
`else
    logic unused_retire_edge;
    assign unused_retire_edge = retire_edge;
`endif

endmodule
